// File: rtl/hci_core_mem_responder.sv
// HCI core target: word-addressed memory behind a req/gnt port, fixed-latency
// response pipeline and an in-order response FIFO. Grants are credit based, so
// the FIFO can never overflow.
module hci_core_mem_responder #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned BW         = 8,
  parameter int unsigned UW         = 1,
  parameter int unsigned NWORDS     = 1024,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tcdm_req,
  output logic             tcdm_gnt,
  input  logic [AW-1:0]    tcdm_add,
  input  logic             tcdm_we_n,
  input  logic [DW-1:0]    tcdm_data,
  input  logic [DW/BW-1:0] tcdm_be,
  input  logic [UW-1:0]    tcdm_user,
  input  logic             tcdm_lrdy,
  output logic [DW-1:0]    tcdm_r_data,
  output logic             tcdm_r_valid,
  output logic             tcdm_r_opc,
  output logic [UW-1:0]    tcdm_r_user
);

  localparam int unsigned NB  = DW / BW;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned IW  = $clog2(NWORDS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  // Response entry layout: {data, opc, user}
  localparam int unsigned RW  = DW + 1 + UW;

  logic [DW-1:0] mem [NWORDS];

  logic [AW-1:0] word_addr;
  logic [IW-1:0] word_idx;
  logic          in_range;
  logic          grant;
  logic          pop;

  logic [CW-1:0] outstanding_q;
  logic          credit_ok;

  logic [DW-1:0] resp_data;
  logic          resp_opc;
  logic [RW-1:0] resp_entry;

  logic          push_valid;
  logic [RW-1:0] push_entry;

  logic [RW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [RW-1:0] head;

  assign word_addr = tcdm_add >> OFF;
  assign word_idx  = tcdm_add[OFF +: IW];
  assign in_range  = word_addr < AW'(NWORDS);

  // A credit freed by a pop only becomes usable in the following cycle.
  assign credit_ok = outstanding_q < CW'(FIFO_DEPTH);
  assign tcdm_gnt  = tcdm_req & ~rst_i & credit_ok;
  assign grant     = tcdm_gnt;

  assign tcdm_r_valid = fifo_cnt_q != '0;
  assign pop          = tcdm_r_valid & tcdm_lrdy;

  // Byte-masked store into the array at the grant edge; the array itself has no reset.
  always_ff @(posedge clk_i) begin
    if (grant && !tcdm_we_n && in_range) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (tcdm_be[i]) begin
          mem[word_idx][i*BW +: BW] <= tcdm_data[i*BW +: BW];
        end
      end
    end
  end

  // Build the response for the request being granted this cycle.
  always_comb begin
    resp_data = '0;
    resp_opc  = 1'b0;
    if (!in_range) begin
      resp_opc = 1'b1;
    end else if (tcdm_we_n) begin
      resp_data = mem[word_idx];
    end
  end

  assign resp_entry = {resp_data, resp_opc, tcdm_user};

  // LATENCY-1 register stages between the grant edge and the FIFO write.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = grant;
    assign push_entry = resp_entry;
  end else begin : g_pipe
    localparam int unsigned NS = LATENCY - 1;

    logic [NS-1:0] pv_q;
    logic [RW-1:0] pe_q [NS];

    // Shift the granted responses down the delay line.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pv_q <= '0;
        for (int s = 0; s < int'(NS); s++) begin
          pe_q[s] <= '0;
        end
      end else begin
        pv_q[0] <= grant;
        pe_q[0] <= resp_entry;
        for (int s = 1; s < int'(NS); s++) begin
          pv_q[s] <= pv_q[s-1];
          pe_q[s] <= pe_q[s-1];
        end
      end
    end

    assign push_valid = pv_q[NS-1];
    assign push_entry = pe_q[NS-1];
  end

  // Outstanding = pipeline occupancy + FIFO occupancy, tracked as one counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(grant) - CW'(pop);
    end
  end

  // FIFO pointers and fill level; push and pop may coincide, even when full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push_valid) - CW'(pop);
    end
  end

  // FIFO storage; contents are only observed through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_valid) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  // Response outputs read zero whenever the FIFO is empty (including reset).
  always_comb begin
    tcdm_r_data = '0;
    tcdm_r_opc  = 1'b0;
    tcdm_r_user = '0;
    if (tcdm_r_valid) begin
      tcdm_r_data = head[RW-1 -: DW];
      tcdm_r_opc  = head[UW];
      tcdm_r_user = head[UW-1:0];
    end
  end

`ifndef SYNTHESIS
  a_gnt_needs_req : assert property (@(posedge clk_i) tcdm_gnt |-> tcdm_req);

  a_resp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (tcdm_r_valid && !tcdm_lrdy) |=> (tcdm_r_valid && $stable(tcdm_r_data) &&
                                      $stable(tcdm_r_opc) && $stable(tcdm_r_user)));

  a_outstanding_bound : assert property (@(posedge clk_i)
    outstanding_q <= CW'(FIFO_DEPTH));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (push_valid && fifo_cnt_q == CW'(FIFO_DEPTH)) |-> pop);
`endif

endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Directed bench for hci_core_mem_responder: one LATENCY=1 instance for the
// functional scenarios and one LATENCY=3 instance (8-bit user) for ordering.
module tb_hci_core_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic        req, gnt, we_n, lrdy, r_valid, r_opc;
  logic [31:0] add, data, r_data;
  logic [3:0]  be;
  logic        user, r_user;

  // LATENCY=3 instance
  logic        req3, gnt3, we_n3, lrdy3, r_valid3, r_opc3;
  logic [31:0] add3, data3, r_data3;
  logic [3:0]  be3;
  logic [7:0]  user3, r_user3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hci_core_mem_responder #(.LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst), .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add),
    .tcdm_we_n(we_n), .tcdm_data(data), .tcdm_be(be), .tcdm_user(user), .tcdm_lrdy(lrdy),
    .tcdm_r_data(r_data), .tcdm_r_valid(r_valid), .tcdm_r_opc(r_opc), .tcdm_r_user(r_user)
  );

  hci_core_mem_responder #(.LATENCY(3), .UW(8)) dut3 (
    .clk_i(clk), .rst_i(rst), .tcdm_req(req3), .tcdm_gnt(gnt3), .tcdm_add(add3),
    .tcdm_we_n(we_n3), .tcdm_data(data3), .tcdm_be(be3), .tcdm_user(user3),
    .tcdm_lrdy(lrdy3), .tcdm_r_data(r_data3), .tcdm_r_valid(r_valid3), .tcdm_r_opc(r_opc3),
    .tcdm_r_user(r_user3)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic u);
    req  = r;
    we_n = w;
    add  = a;
    data = d;
    be   = b;
    user = u;
  endtask

  task automatic test_reset();
    drv(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", gnt); else pass_cnt++;
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", r_valid);
    else pass_cnt++;
    total_cnt++;
    if ({r_data, r_opc, r_user} !== 34'h0)
      $display("FAIL reset_rout: got %h/%b/%b want 0/0/0", r_data, r_opc, r_user);
    else pass_cnt++;
    total_cnt++;
    if (r_valid3 !== 1'b0) $display("FAIL reset_rvalid3: got %b want 0", r_valid3);
    else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    next_cycle();
  endtask

  task automatic test_store_load();
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] e [2];
    w = '{1'b0, 1'b1};
    a = '{32'h10, 32'h10};
    d = '{32'hDEADBEEF, 32'h0};
    e = '{32'h0, 32'hDEADBEEF};
    lrdy = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      if (c < 2) drv(1'b1, w[c], a[c], d[c], 4'hF, 1'b0);
      else drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      if (c < 2) begin
        total_cnt++;
        if (gnt !== 1'b1) $display("FAIL sl_gnt[%0d]: got %b want 1", c, gnt);
        else pass_cnt++;
      end
      total_cnt++;
      if (r_valid !== (c > 0)) $display("FAIL sl_rvalid[%0d]: got %b want %b", c, r_valid, c > 0);
      else pass_cnt++;
      if (c > 0) begin
        total_cnt++;
        if (r_data !== e[c-1] || r_opc !== 1'b0)
          $display("FAIL sl_resp[%0d]: got %h/%b want %h/0", c, r_data, r_opc, e[c-1]);
        else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_byte_enable();
    logic        w [3];
    logic [31:0] d [3];
    logic [3:0]  b [3];
    logic [31:0] e [3];
    w = '{1'b0, 1'b0, 1'b1};
    d = '{32'h11223344, 32'hAABBCCDD, 32'h0};
    b = '{4'hF, 4'h5, 4'h0};
    e = '{32'h0, 32'h0, 32'h11BB33DD};
    lrdy = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c < 3) drv(1'b1, w[c], 32'h20, d[c], b[c], 1'b0);
      else drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      if (c > 0) begin
        total_cnt++;
        if (r_valid !== 1'b1 || r_data !== e[c-1] || r_opc !== 1'b0)
          $display("FAIL be_resp[%0d]: got %b/%h/%b want 1/%h/0",
                   c, r_valid, r_data, r_opc, e[c-1]);
        else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    bit          eg [12];
    bit          ev [12];
    logic [31:0] ed [12];
    int          k;
    logic        g;
    eg = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    ev = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    ed = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
           32'hA0, 32'h0};
    lrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0);
      next_cycle();
    end
    drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    next_cycle();
    next_cycle();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      drv(c < 8, 1'b1, 32'h40 + 32'(4 * (k % 4)), 32'h0, 4'h0, 1'b0);
      lrdy = (c >= 6);
      @(negedge clk);
      g = gnt;
      total_cnt++;
      if (gnt !== eg[c]) $display("FAIL bp_gnt[%0d]: got %b want %b", c, gnt, eg[c]);
      else pass_cnt++;
      total_cnt++;
      if (r_valid !== ev[c]) $display("FAIL bp_rvalid[%0d]: got %b want %b", c, r_valid, ev[c]);
      else pass_cnt++;
      if (ev[c]) begin
        total_cnt++;
        if (r_data !== ed[c]) $display("FAIL bp_head[%0d]: got %h want %h", c, r_data, ed[c]);
        else pass_cnt++;
      end
      next_cycle();
      if (g) k++;
    end
  endtask

  task automatic test_out_of_range();
    logic        w [4];
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic        u [4];
    logic [31:0] ed [4];
    logic        eo [4];
    w  = '{1'b0, 1'b0, 1'b1, 1'b1};
    a  = '{32'h0, 32'd4096, 32'd4096, 32'h0};
    d  = '{32'h5A5A1234, 32'hFFFFFFFF, 32'h0, 32'h0};
    u  = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{32'h0, 32'h0, 32'h0, 32'h5A5A1234};
    eo = '{1'b0, 1'b1, 1'b1, 1'b0};
    lrdy = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) drv(1'b1, w[c], a[c], d[c], 4'hF, u[c]);
      else drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      if (c > 0) begin
        total_cnt++;
        if (r_valid !== 1'b1 || r_data !== ed[c-1] || r_opc !== eo[c-1] || r_user !== u[c-1])
          $display("FAIL oor_resp[%0d]: got %b/%h/%b/%b want 1/%h/%b/%b", c, r_valid, r_data,
                   r_opc, r_user, ed[c-1], eo[c-1], u[c-1]);
        else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_latency3();
    int gcyc [11];
    int issue, rx, cyc, tries;
    for (int t = 1; t <= 10; t++) begin
      tries = 0;
      lrdy3 = 1'b1;
      req3  = 1'b1;
      we_n3 = 1'b0;
      add3  = 32'(4 * t);
      data3 = 32'h1000 + 32'(t);
      be3   = 4'hF;
      user3 = 8'h0;
      @(negedge clk);
      while (gnt3 !== 1'b1 && tries < 20) begin
        next_cycle();
        @(negedge clk);
        tries++;
      end
      next_cycle();
    end
    req3 = 1'b0;
    for (int i = 0; i < 8; i++) next_cycle();
    issue = 1;
    rx    = 1;
    cyc   = 0;
    for (int i = 0; i < 11; i++) gcyc[i] = 0;
    while (rx <= 10 && cyc < 300) begin
      req3  = (issue <= 10);
      we_n3 = 1'b1;
      add3  = 32'(4 * issue);
      user3 = 8'(issue);
      lrdy3 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (gnt3) begin
        gcyc[issue] = cyc;
        issue++;
      end
      if (r_valid3 && lrdy3) begin
        total_cnt++;
        if (r_user3 !== 8'(rx) || r_data3 !== 32'h1000 + 32'(rx) || r_opc3 !== 1'b0)
          $display("FAIL lat3_resp[%0d]: got %0d/%h/%b want %0d/%h/0",
                   rx, r_user3, r_data3, r_opc3, rx, 32'h1000 + 32'(rx));
        else pass_cnt++;
        total_cnt++;
        if (cyc - gcyc[rx] < 3)
          $display("FAIL lat3_delay[%0d]: got %0d cycles want >=3", rx, cyc - gcyc[rx]);
        else pass_cnt++;
        rx++;
      end
      next_cycle();
      cyc++;
    end
    total_cnt++;
    if (rx != 11) $display("FAIL lat3_count: got %0d responses want 10", rx - 1);
    else pass_cnt++;
    req3  = 1'b0;
    lrdy3 = 1'b1;
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    total_cnt++;
    if (r_valid3 !== 1'b0) $display("FAIL lat3_extra: got r_valid %b want 0", r_valid3);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_outstanding();
    lrdy = 1'b1;
    drv(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0);
    next_cycle();
    drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    next_cycle();
    next_cycle();
    lrdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drv(1'b1, 1'b1, 32'h80, 32'h0, 4'h0, 1'(c));
      @(negedge clk);
      total_cnt++;
      if (gnt !== 1'b1) $display("FAIL rst_fill_gnt[%0d]: got %b want 1", c, gnt);
      else pass_cnt++;
      next_cycle();
    end
    drv(1'b1, 1'b1, 32'h80, 32'h0, 4'h0, 1'b1);
    total_cnt++;
    if (r_valid !== 1'b1) $display("FAIL rst_pending: got r_valid %b want 1", r_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (r_valid !== 1'b0 || gnt !== 1'b0)
      $display("FAIL rst_async: got r_valid %b gnt %b want 0 0", r_valid, gnt);
    else pass_cnt++;
    next_cycle();
    rst  = 1'b0;
    lrdy = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (gnt !== 1'b1 || r_valid !== 1'b0)
      $display("FAIL rst_release: got gnt %b r_valid %b want 1 0", gnt, r_valid);
    else pass_cnt++;
    next_cycle();
    drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (r_valid !== 1'b1 || r_data !== 32'hCAFEF00D || r_user !== 1'b1)
      $display("FAIL rst_mem_kept: got %b/%h/%b want 1/cafef00d/1", r_valid, r_data, r_user);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (r_valid !== 1'b0) $display("FAIL rst_no_stale: got r_valid %b want 0", r_valid);
    else pass_cnt++;
    next_cycle();
  endtask

  initial begin
    rst   = 1'b0;
    drv(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    lrdy  = 1'b1;
    req3  = 1'b0;
    we_n3 = 1'b1;
    add3  = 32'h0;
    data3 = 32'h0;
    be3   = 4'h0;
    user3 = 8'h0;
    lrdy3 = 1'b1;
    #1 rst = 1'b1;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_out_of_range();
    test_latency3();
    test_reset_outstanding();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
